// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Brief   : Arbitrates a CPU port (0) and a DMA port (1) onto one synchronous
//           single-port RAM. Round-robin by default; defining the macro
//           CPU_PRIORITY_EN gives port 0 fixed priority instead.
// Rev     : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] RDATA0,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [DATA_WIDTH-1:0] RAM_DO,
  input  logic [DATA_WIDTH-1:0] RAM_DI,
  output logic                  RAM_CS_N,
  output logic                  RAM_OE_N,
  output logic                  RAM_WR_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  win_q, win_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [DATA_WIDTH-1:0] ram_do_q, ram_do_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  pick1;
  logic                  sel_we;
`ifndef CPU_PRIORITY_EN
  logic                  last_q, last_d;
`endif

  // pick1: port 1 wins the current IDLE arbitration
  always_comb begin
`ifdef CPU_PRIORITY_EN
    pick1 = REQ1 & ~REQ0;
`else
    pick1 = REQ1 & (~REQ0 | ~last_q);
`endif
    sel_we = pick1 ? WE1 : WE0;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    ram_a_d  = ram_a_q;
    ram_do_d = ram_do_q;
    cs_n_d   = cs_n_q;
    oe_n_d   = oe_n_q;
    wr_n_d   = wr_n_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef CPU_PRIORITY_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ0 | REQ1) begin
          win_d   = pick1;
          we_d    = sel_we;
          ram_a_d = pick1 ? ADDR1 : ADDR0;
          if (sel_we) begin
            ram_do_d = pick1 ? WDATA1 : WDATA0;
          end
          cs_n_d  = 1'b0;
          oe_n_d  = sel_we;
          wr_n_d  = ~sel_we;
`ifndef CPU_PRIORITY_EN
          last_d  = pick1;
`endif
          state_d = ACC;
        end
      end
      ACC: begin
        if (we_q) begin
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // RAM_DI carries the word addressed during ACC
        if (win_q) begin
          rdata1_d = RAM_DI;
        end else begin
          rdata0_d = RAM_DI;
        end
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      ram_a_q  <= '0;
      ram_do_q <= '0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef CPU_PRIORITY_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      ram_a_q  <= ram_a_d;
      ram_do_q <= ram_do_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      wr_n_q   <= wr_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef CPU_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end

  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign RAM_A    = ram_a_q;
  assign RAM_DO   = ram_do_q;
  assign RAM_CS_N = cs_n_q;
  assign RAM_OE_N = oe_n_q;
  assign RAM_WR_N = wr_n_q;

endmodule
`default_nettype wire
